matrix_op_sequencer: RTL and testbench

Parametrised top-level control sequencer for the matrix calculator. It takes UART bytes and the debounced S0/S2 buttons. It drives matrix entry into an N-slot matrix store and selects operand slots. It dispatches one of four compute engines through a one-hot start/done handshake. Compared with the single-pair controller it replaces, it adds:
- run-time operand-slot selection;
- dimension and slot validation with a timed error display;
- an optional compute watchdog.

---
 rtl/matrix_op_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_sequencer.sv
// Control sequencer for the matrix calculator: matrix entry, operand selection,
// engine dispatch and timed error display. Define MATOP_WDOG_EN for the compute watchdog.
module matrix_op_sequencer #(
    parameter int DATA_W   = 8,
    parameter int DIM_W    = 4,
    parameter int MAX_DIM  = 5,
    parameter int SLOT_W   = 2,
    parameter int ERR_HOLD = 50_000_000,
    parameter int WDOG_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        func_sel,
    input  logic [1:0]        op_mode,
    input  logic              btn_start,
    input  logic              btn_back,
    input  logic              uart_rx_done,
    input  logic [DATA_W-1:0] uart_rx_data,
    output logic              store_wen,
    output logic [SLOT_W-1:0] store_slot,
    output logic [DIM_W-1:0]  store_m,
    output logic [DIM_W-1:0]  store_n,
    output logic [DATA_W-1:0] store_elem_in,
    output logic              store_elem_valid,
    input  logic              storage_input_done,
    output logic [3:0]        op_start,
    input  logic [3:0]        op_busy,
    input  logic [3:0]        op_done,
    output logic [SLOT_W-1:0] op_slot_a,
    output logic [SLOT_W-1:0] op_slot_b,
    output logic [DATA_W-1:0] scalar_value,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        main_state_out,
    output logic [3:0]        sub_state_out
);

    typedef enum logic [2:0] {M_MENU, M_INPUT, M_GEN, M_DISP, M_COMP} main_t;
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,  S_GET_M = 4'd1,  S_GET_N = 4'd2,  S_CHECK = 4'd3,
        S_STORE = 4'd4,  S_RX    = 4'd5,  S_GET_A = 4'd6,  S_GET_B = 4'd7,
        S_GET_S = 4'd8,  S_WAIT  = 4'd9,  S_RUN   = 4'd10, S_DONE  = 4'd11,
        S_ERR   = 4'd12
    } sub_t;

    localparam int ECW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
    localparam logic [ECW-1:0]   ERR_LOAD = ECW'(ERR_HOLD - 1);
    localparam logic [DIM_W-1:0] MAXD     = DIM_W'(MAX_DIM);

    main_t main_q, main_d;
    sub_t  sub_q, sub_d;

    logic [SLOT_W-1:0] wp;
    logic [ECW-1:0]    err_cnt;

    logic       ld_m, ld_n, wen_d, elem_ld, wp_inc, ld_a, ld_b, ld_s, start_d;
    logic       err_set;
    logic [1:0] code_d;
    logic       dim_bad, slot_bad;

`ifdef MATOP_WDOG_EN
    localparam int WCW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WCW-1:0] WD_LAST = WCW'(WDOG_CYC - 1);
    logic [WCW-1:0] wd_cnt;
`endif

    assign dim_bad  = (store_m == '0) || (store_m > MAXD) ||
                      (store_n == '0) || (store_n > MAXD);
    assign slot_bad = (uart_rx_data[DATA_W-1:SLOT_W] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= M_MENU;
            sub_q  <= S_IDLE;
        end else begin
            main_q <= main_d;
            sub_q  <= sub_d;
        end
    end

    always_comb begin
        main_d  = main_q;
        sub_d   = sub_q;
        ld_m    = 1'b0;
        ld_n    = 1'b0;
        wen_d   = 1'b0;
        elem_ld = 1'b0;
        wp_inc  = 1'b0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_s    = 1'b0;
        start_d = 1'b0;
        err_set = 1'b0;
        code_d  = 2'b00;
        // Back wins over every other event, so nothing below is evaluated with it.
        if (main_q != M_MENU && btn_back) begin
            main_d = M_MENU;
            sub_d  = S_IDLE;
        end else begin
            case (sub_q)
                S_IDLE: begin
                    if (main_q == M_MENU && btn_start) begin
                        case (func_sel)
                            2'b00: begin main_d = M_INPUT; sub_d = S_GET_M; end
                            2'b01: main_d = M_GEN;
                            2'b10: main_d = M_DISP;
                            default: begin main_d = M_COMP; sub_d = S_GET_A; end
                        endcase
                    end
                end
                S_GET_M: if (uart_rx_done) begin ld_m = 1'b1; sub_d = S_GET_N; end
                S_GET_N: if (uart_rx_done) begin ld_n = 1'b1; sub_d = S_CHECK; end
                S_CHECK: begin
                    if (dim_bad) begin
                        err_set = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        wen_d = 1'b1;
                        sub_d = S_STORE;
                    end
                end
                S_STORE: begin
                    elem_ld = uart_rx_done;
                    sub_d   = S_RX;
                end
                S_RX: begin
                    elem_ld = uart_rx_done;
                    if (storage_input_done) begin
                        wp_inc = 1'b1;
                        sub_d  = S_GET_M;
                    end
                end
                S_GET_A: begin
                    if (uart_rx_done) begin
                        if (slot_bad) begin
                            err_set = 1'b1;
                            code_d  = 2'b10;
                        end else begin
                            ld_a = 1'b1;
                            case (op_mode)
                                2'b00, 2'b11: sub_d = S_GET_B;
                                2'b10:        sub_d = S_GET_S;
                                default:      sub_d = S_WAIT;
                            endcase
                        end
                    end
                end
                S_GET_B: begin
                    if (uart_rx_done) begin
                        if (slot_bad) begin
                            err_set = 1'b1;
                            code_d  = 2'b10;
                        end else begin
                            ld_b  = 1'b1;
                            sub_d = S_WAIT;
                        end
                    end
                end
                S_GET_S: if (uart_rx_done) begin ld_s = 1'b1; sub_d = S_WAIT; end
                S_WAIT: begin
                    if (btn_start) begin
                        if (op_busy[op_mode]) begin
                            err_set = 1'b1;
                            code_d  = 2'b11;
                        end else begin
                            start_d = 1'b1;
                            sub_d   = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (op_done[op_mode]) sub_d = S_DONE;
`ifdef MATOP_WDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        err_set = 1'b1;
                        code_d  = 2'b11;
                    end
`endif
                end
                S_DONE: if (btn_start) sub_d = S_GET_A;
                S_ERR: begin
                    if (err_cnt == '0) sub_d = (main_q == M_INPUT) ? S_GET_M : S_GET_A;
                end
                default: sub_d = S_IDLE;
            endcase
            if (err_set) sub_d = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_wen        <= 1'b0;
            store_m          <= '0;
            store_n          <= '0;
            store_elem_in    <= '0;
            store_elem_valid <= 1'b0;
            wp               <= '0;
            op_start         <= 4'b0000;
            op_slot_a        <= '0;
            op_slot_b        <= '0;
            scalar_value     <= '0;
            err              <= 1'b0;
            err_code         <= 2'b00;
            err_cnt          <= '0;
        end else begin
            store_wen        <= wen_d;
            store_elem_valid <= elem_ld;
            op_start         <= start_d ? (4'b0001 << op_mode) : 4'b0000;
            if (ld_m)    store_m       <= uart_rx_data[DIM_W-1:0];
            if (ld_n)    store_n       <= uart_rx_data[DIM_W-1:0];
            if (elem_ld) store_elem_in <= uart_rx_data;
            if (wp_inc)  wp            <= wp + 1'b1;
            if (ld_a)    op_slot_a     <= uart_rx_data[SLOT_W-1:0];
            if (ld_b)    op_slot_b     <= uart_rx_data[SLOT_W-1:0];
            if (ld_s)    scalar_value  <= uart_rx_data;
            err <= (sub_d == S_ERR);
            if (err_set)                 err_code <= code_d;
            else if (sub_d != S_ERR)     err_code <= 2'b00;
            if (err_set)                 err_cnt <= ERR_LOAD;
            else if (sub_q == S_ERR && err_cnt != '0) err_cnt <= err_cnt - 1'b1;
        end
    end

`ifdef MATOP_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wd_cnt <= '0;
        else if (start_d)        wd_cnt <= '0;
        else if (sub_q == S_RUN) wd_cnt <= wd_cnt + 1'b1;
    end
`endif

    assign store_slot    = wp;
    assign sub_state_out = sub_q;

    // GENERATE and DISPLAY are placeholders and share one reported code.
    always_comb begin
        case (main_q)
            M_INPUT: main_state_out = 2'b01;
            M_GEN,
            M_DISP:  main_state_out = 2'b10;
            M_COMP:  main_state_out = 2'b11;
            default: main_state_out = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed/randomized bench for matrix_op_sequencer with a queue-based reference model.
module tb_matrix_op_sequencer;
    localparam int H  = 8;
    localparam int WD = 16;
    localparam int SUB_IDLE = 0, SUB_GET_M = 1, SUB_GET_N = 2, SUB_CHECK = 3,
                   SUB_RX = 5, SUB_GET_A = 6, SUB_WAIT = 9, SUB_RUN = 10,
                   SUB_DONE = 11, SUB_ERR = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] func_sel = 2'b00;
    logic [1:0] op_mode = 2'b00;
    logic       btn_start = 1'b0, btn_back = 1'b0;
    logic       uart_rx_done = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       store_wen, store_elem_valid, storage_input_done = 1'b0;
    logic [1:0] store_slot, op_slot_a, op_slot_b, err_code, main_state_out;
    logic [3:0] store_m, store_n, op_start, sub_state_out;
    logic [3:0] op_busy = 4'b0000, op_done = 4'b0000;
    logic [7:0] store_elem_in, scalar_value;
    logic       err;

    int total = 0;
    int bad = 0;
    int wp_m = 0;
    int exp_elems = 0;
    int mon_elems = 0;
    int exp_slots[$];
    int mon_slots[$];
    logic [1:0] exp_a = 2'd0, exp_b = 2'd0;
    logic [7:0] exp_s = 8'd0;

    always #5 clk = ~clk;

    matrix_op_sequencer #(
        .DATA_W(8), .DIM_W(4), .MAX_DIM(5), .SLOT_W(2), .ERR_HOLD(H), .WDOG_CYC(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .func_sel(func_sel), .op_mode(op_mode),
        .btn_start(btn_start), .btn_back(btn_back),
        .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
        .store_wen(store_wen), .store_slot(store_slot), .store_m(store_m),
        .store_n(store_n), .store_elem_in(store_elem_in),
        .store_elem_valid(store_elem_valid), .storage_input_done(storage_input_done),
        .op_start(op_start), .op_busy(op_busy), .op_done(op_done),
        .op_slot_a(op_slot_a), .op_slot_b(op_slot_b), .scalar_value(scalar_value),
        .err(err), .err_code(err_code), .main_state_out(main_state_out),
        .sub_state_out(sub_state_out)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (store_elem_valid) mon_elems++;
            if (store_wen) mon_slots.push_back(int'(store_slot));
        end
    end

    initial begin
        #500_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_data = b;
        uart_rx_done = 1'b1;
        tick();
        uart_rx_done = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b1; tick(); btn_start = 1'b0;
    endtask

    task automatic press_back();
        btn_back = 1'b1; tick(); btn_back = 1'b0;
    endtask

    task automatic do_entry(input int m, input int n, input bit merge_last);
        logic [7:0] v;
        send_byte(8'(m));
        send_byte(8'(n));
        tick();
        chk("wen_pulse", store_wen, 1);
        chk("wen_slot", store_slot, wp_m);
        chk("wen_dims", {store_m, store_n}, {4'(m), 4'(n)});
        tick();
        chk("wen_width", store_wen, 0);
        for (int k = 0; k < m * n; k++) begin
            v = 8'($urandom);
            if (merge_last && k == m * n - 1) storage_input_done = 1'b1;
            send_byte(v);
            storage_input_done = 1'b0;
            chk("elem", {store_elem_valid, store_elem_in}, {1'b1, v});
        end
        exp_elems += m * n;
        if (!merge_last) begin
            storage_input_done = 1'b1; tick(); storage_input_done = 1'b0;
        end
        exp_slots.push_back(wp_m);
        wp_m = (wp_m + 1) % 4;
        chk("entry_ret", sub_state_out, SUB_GET_M);
        chk("wp_next", store_slot, wp_m);
    endtask

    task automatic err_duration(input string tag, input int code, input int ret_sub,
                                input logic [7:0] junk);
        int c = 0;
        chk({tag, "_err"}, err, 1);
        chk({tag, "_code"}, err_code, code);
        while (err === 1'b1 && c < 100) begin
            c++;
            if (c == 2) send_byte(junk);
            else tick();
        end
        chk({tag, "_len"}, c, H);
        chk({tag, "_ret"}, sub_state_out, ret_sub);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                          input logic [7:0] s);
        int w;
        op_mode = op;
        send_byte({6'd0, a});
        exp_a = a;
        if (op == 2'b00 || op == 2'b11) begin send_byte({6'd0, b}); exp_b = b; end
        if (op == 2'b10) begin send_byte(s); exp_s = s; end
        chk("op_wait", sub_state_out, SUB_WAIT);
        press_start();
        chk("op_start", op_start, 4'b0001 << op);
        chk("op_operands", {op_slot_a, op_slot_b, scalar_value}, {exp_a, exp_b, exp_s});
        tick();
        chk("op_start_width", op_start, 0);
        w = $urandom_range(0, 4);
        repeat (w) tick();
        chk("run_stable", {sub_state_out, op_slot_a, op_slot_b, scalar_value},
            {4'(SUB_RUN), exp_a, exp_b, exp_s});
        op_done = 4'b0001 << op; tick(); op_done = 4'b0000;
        chk("op_done", sub_state_out, SUB_DONE);
        press_start();
        chk("done_restart", sub_state_out, SUB_GET_A);
    endtask

    initial begin
        int c;
        logic [3:0] bd;
        #1;
        chk("rst_a", {store_wen, store_slot, store_m, store_n, store_elem_in,
                      store_elem_valid, op_start}, 0);
        chk("rst_b", {op_slot_a, op_slot_b, scalar_value, err, err_code,
                      main_state_out, sub_state_out}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // generate state only leaves through back
        func_sel = 2'b01; press_start();
        chk("gen_enter", {main_state_out, sub_state_out}, {2'b10, 4'd0});
        press_start();
        chk("gen_stay", main_state_out, 2'b10);
        press_back();
        chk("gen_back", main_state_out, 2'b00);

        func_sel = 2'b00; press_start();
        chk("input_enter", sub_state_out, SUB_GET_M);
        do_entry(2, 3, 1'b0);

        send_byte(8'd0); send_byte(8'd3); tick();
        err_duration("dim_m0", 1, SUB_GET_M, 8'h03);
        chk("dim_m0_discard", store_m, 0);
        send_byte(8'd6); send_byte(8'd2); tick();
        err_duration("dim_m6", 1, SUB_GET_M, 8'h03);
        chk("dim_m6_discard", store_m, 6);
        bd = 4'($urandom_range(6, 15));
        send_byte(8'd1); send_byte({4'd0, bd}); tick();
        err_duration("dim_nrand", 1, SUB_GET_M, 8'h03);

        for (int e = 0; e < 4; e++)
            do_entry($urandom_range(1, 5), $urandom_range(1, 5), e == 2);
        chk("slot_count", mon_slots.size(), exp_slots.size());
        for (int i = 0; i < exp_slots.size() && i < mon_slots.size(); i++)
            chk("slot_seq", mon_slots[i], exp_slots[i]);
        chk("elem_count", mon_elems, exp_elems);
        press_back();
        chk("input_back", {main_state_out, sub_state_out, err}, 0);

        func_sel = 2'b11; press_start();
        chk("comp_enter", sub_state_out, SUB_GET_A);
        op_mode = 2'b11;
        send_byte(8'd1); send_byte(8'd2);
        press_start();
        chk("mm_start", op_start, 4'b1000);
        chk("mm_slots", {op_slot_a, op_slot_b}, {2'd1, 2'd2});
        exp_a = 2'd1; exp_b = 2'd2;
        tick();
        chk("mm_start_width", op_start, 0);
        op_done = 4'b0100; tick(); op_done = 4'b0000;
        chk("mm_other_done", sub_state_out, SUB_RUN);
        op_done = 4'b1000; tick(); op_done = 4'b0000;
        chk("mm_done", sub_state_out, SUB_DONE);
        press_start();

        for (int i = 0; i < 6; i++)
            run_op(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));

        op_mode = 2'b01;
        send_byte(8'h05);
        err_duration("slot_bad", 2, SUB_GET_A, 8'h02);
        chk("slot_bad_keep", op_slot_a, exp_a);

        op_mode = 2'b00; op_busy = 4'b0001;
        send_byte(8'd1); send_byte(8'd3);
        exp_a = 2'd1; exp_b = 2'd3;
        press_start();
        chk("busy_no_start", op_start, 0);
        chk("busy_err", {err, err_code, sub_state_out}, {1'b1, 2'b11, 4'(SUB_ERR)});
        op_busy = 4'b0000;
        press_back();
        chk("busy_back", {err, err_code, main_state_out}, 0);
        chk("back_keeps_ops", {op_slot_a, op_slot_b}, {exp_a, exp_b});

        press_start();
        op_mode = 2'b01;
        send_byte(8'd2); press_start();
        chk("bk_run", sub_state_out, SUB_RUN);
        btn_back = 1'b1; op_done = 4'b0010; tick();
        btn_back = 1'b0; op_done = 4'b0000;
        chk("back_vs_done", {main_state_out, sub_state_out, err}, 0);

        press_start();
        send_byte(8'd0); press_start();
        c = 0;
        while (sub_state_out == 4'(SUB_RUN) && c < 40) begin tick(); c++; end
`ifdef MATOP_WDOG_EN
        chk("wdog_cycles", c, WD);
        err_duration("wdog", 3, SUB_GET_A, 8'h01);
`else
        chk("no_wdog", {c, err}, {32'd40, 1'b0});
`endif
        press_back();

        func_sel = 2'b00; press_start();
        send_byte(8'd2); send_byte(8'd2); tick(); tick();
        chk("rx_reach", sub_state_out, SUB_RX);
        uart_rx_data = 8'hA5; uart_rx_done = 1'b1; rst_n = 1'b0;
        #1;
        chk("midrst_out", {store_wen, store_elem_valid, store_slot, op_start, err,
                           main_state_out, sub_state_out}, 0);
        tick();
        uart_rx_done = 1'b0; rst_n = 1'b1;
        tick();
        chk("midrst_after", {store_wen, store_elem_valid, store_slot, store_elem_in,
                             main_state_out, sub_state_out}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
